// File: rtl/and8_gates_mux4_pkg.sv
// Shared types, reset constants and the gate-bank helper for and8_gates_mux4.
package and8_gates_mux4_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [1:0] sel_t;
    typedef logic [7:0] byte_t;

    typedef struct packed {
        nibble_t yinv;
        nibble_t yand;
        nibble_t yor;
        nibble_t yxor;
        nibble_t ynand;
        nibble_t ynor;
    } gate_res_t;

    typedef enum logic [1:0] {
        MUX_CASE  = 2'd0,
        MUX_TREE  = 2'd1,
        MUX_ANDOR = 2'd2
    } mux_style_t;

    localparam nibble_t   RST_NIBBLE = 4'b0000;
    localparam gate_res_t RST_GATES  = '{default: RST_NIBBLE};

    function automatic gate_res_t gate_bank(input nibble_t a, input nibble_t b);
        gate_res_t res;
        res.yinv  = ~a;
        res.yand  = a & b;
        res.yor   = a | b;
        res.yxor  = a ^ b;
        res.ynand = ~(a & b);
        res.ynor  = ~(a | b);
        return res;
    endfunction

endpackage

// File: rtl/and8_gates_mux4_mux4.sv
// a8gm_mux4: combinational 4:1 nibble mux; STYLE picks one of three
// structurally different implementations so they can cross-check each other.
module a8gm_mux4
    import and8_gates_mux4_pkg::*;
#(
    parameter mux_style_t STYLE = MUX_CASE
) (
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [1:0] s,
    output logic [3:0] y
);

    if (STYLE == MUX_TREE) begin : g_tree
        nibble_t w_lo;
        nibble_t w_hi;
        assign w_lo = s[0] ? d1 : d0;
        assign w_hi = s[0] ? d3 : d2;
        assign y    = s[1] ? w_hi : w_lo;
    end else if (STYLE == MUX_ANDOR) begin : g_andor
        logic [3:0] w_dec;
        assign w_dec = {( s[1] &  s[0]), ( s[1] & ~s[0]),
                        (~s[1] &  s[0]), (~s[1] & ~s[0])};
        assign y = ({4{w_dec[0]}} & d0) | ({4{w_dec[1]}} & d1) |
                   ({4{w_dec[2]}} & d2) | ({4{w_dec[3]}} & d3);
    end else begin : g_case
        // Select-decoded case form of the mux.
        always_comb begin
            y = RST_NIBBLE;
            case (s)
                2'b00:   y = d0;
                2'b01:   y = d1;
                2'b10:   y = d2;
                2'b11:   y = d3;
                default: y = RST_NIBBLE;
            endcase
        end
    end

endmodule

// File: rtl/and8_gates_mux4.sv
// Registered gate bank, 8-input AND and 4:1 mux with one valid strobe.
// Define AND8_GATES_MUX4_MUX_XCHK_EN to build the triple-redundant mux with sticky mux_err.
module and8_gates_mux4
    import and8_gates_mux4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [7:0] and_a,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [1:0] s,
    output logic       out_valid,
    output logic [3:0] yinv,
    output logic [3:0] yand,
    output logic [3:0] yor,
    output logic [3:0] yxor,
    output logic [3:0] ynand,
    output logic [3:0] ynor,
    output logic       and_y,
    output logic [3:0] mux_y,
    output logic       mux_err
);

    gate_res_t w_gates;
    nibble_t   w_mux_case;

    gate_res_t r_gates;
    logic      r_and_y;
    nibble_t   r_mux_y;
    logic      r_out_valid;

    assign w_gates = gate_bank(a, b);

    a8gm_mux4 #(.STYLE(MUX_CASE)) u_mux_case (
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .s(s), .y(w_mux_case)
    );

    // Result registers load only on accepted operands; out_valid follows in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_gates     <= RST_GATES;
            r_and_y     <= 1'b0;
            r_mux_y     <= RST_NIBBLE;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_gates <= w_gates;
                r_and_y <= &and_a;
                r_mux_y <= w_mux_case;
            end
        end
    end

`ifdef AND8_GATES_MUX4_MUX_XCHK_EN
    nibble_t w_mux_tree;
    nibble_t w_mux_andor;
    logic    w_mux_mismatch;
    logic    r_mux_err;

    a8gm_mux4 #(.STYLE(MUX_TREE)) u_mux_tree (
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .s(s), .y(w_mux_tree)
    );

    a8gm_mux4 #(.STYLE(MUX_ANDOR)) u_mux_andor (
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .s(s), .y(w_mux_andor)
    );

    assign w_mux_mismatch = (w_mux_case != w_mux_tree) || (w_mux_case != w_mux_andor);

    // Sticky disagreement flag, sampled alongside the result it would corrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mux_err <= 1'b0;
        end else begin
            r_mux_err <= r_mux_err | (in_valid & w_mux_mismatch);
        end
    end

    assign mux_err = r_mux_err;
`else
    assign mux_err = 1'b0;
`endif

    assign out_valid = r_out_valid;
    assign yinv      = r_gates.yinv;
    assign yand      = r_gates.yand;
    assign yor       = r_gates.yor;
    assign yxor      = r_gates.yxor;
    assign ynand     = r_gates.ynand;
    assign ynor      = r_gates.ynor;
    assign and_y     = r_and_y;
    assign mux_y     = r_mux_y;

endmodule

// File: tb/tb_and8_gates_mux4.sv
// Scoreboard bench for and8_gates_mux4: driver pushes model results, a
// negedge monitor pops them whenever out_valid is high and checks holds otherwise.
module tb_and8_gates_mux4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a, b, d0, d1, d2, d3;
    logic [7:0] and_a;
    logic [1:0] s;
    logic       out_valid, and_y, mux_err;
    logic [3:0] yinv, yand, yor, yxor, ynand, ynor, mux_y;

    typedef struct packed {
        logic [3:0] e_inv;
        logic [3:0] e_and;
        logic [3:0] e_or;
        logic [3:0] e_xor;
        logic [3:0] e_nand;
        logic [3:0] e_nor;
        logic       e_andy;
        logic [3:0] e_mux;
    } exp_t;

    exp_t sb[$];
    exp_t held;
    int   checks = 0;
    int   errors = 0;

    and8_gates_mux4 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a), .b(b), .and_a(and_a),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .s(s),
        .out_valid(out_valid),
        .yinv(yinv), .yand(yand), .yor(yor), .yxor(yxor), .ynand(ynand), .ynor(ynor),
        .and_y(and_y), .mux_y(mux_y), .mux_err(mux_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_all(input string tag, input exp_t e);
        chk({tag, ".yinv"},  {4'd0, yinv},  {4'd0, e.e_inv});
        chk({tag, ".yand"},  {4'd0, yand},  {4'd0, e.e_and});
        chk({tag, ".yor"},   {4'd0, yor},   {4'd0, e.e_or});
        chk({tag, ".yxor"},  {4'd0, yxor},  {4'd0, e.e_xor});
        chk({tag, ".ynand"}, {4'd0, ynand}, {4'd0, e.e_nand});
        chk({tag, ".ynor"},  {4'd0, ynor},  {4'd0, e.e_nor});
        chk({tag, ".and_y"}, {7'd0, and_y}, {7'd0, e.e_andy});
        chk({tag, ".mux_y"}, {4'd0, mux_y}, {4'd0, e.e_mux});
    endtask

    // Reference: per-bit counting of ones, AND8 as equality to 255, mux as array lookup.
    function automatic exp_t model(input logic [3:0] ta, input logic [3:0] tb_,
                                   input logic [7:0] ta8, input logic [3:0] t0,
                                   input logic [3:0] t1, input logic [3:0] t2,
                                   input logic [3:0] t3, input logic [1:0] ts);
        exp_t m;
        int   ones;
        logic [3:0] dd [4];
        m = '0;
        for (int i = 0; i < 4; i++) begin
            ones = int'(ta[i]) + int'(tb_[i]);
            m.e_inv[i]  = (ta[i] == 1'b0);
            m.e_and[i]  = (ones == 2);
            m.e_or[i]   = (ones >= 1);
            m.e_xor[i]  = (ones == 1);
            m.e_nand[i] = (ones != 2);
            m.e_nor[i]  = (ones == 0);
        end
        m.e_andy = (int'(ta8) == 255);
        dd[0] = t0; dd[1] = t1; dd[2] = t2; dd[3] = t3;
        m.e_mux = dd[int'(ts)];
        return m;
    endfunction

    task automatic drive(input logic v, input logic [3:0] ta, input logic [3:0] tb_,
                         input logic [7:0] ta8, input logic [3:0] t0, input logic [3:0] t1,
                         input logic [3:0] t2, input logic [3:0] t3, input logic [1:0] ts);
        in_valid = v; a = ta; b = tb_; and_a = ta8;
        d0 = t0; d1 = t1; d2 = t2; d3 = t3; s = ts;
        if (v) sb.push_back(model(ta, tb_, ta8, t0, t1, t2, t3, ts));
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop on valid output, otherwise outputs must hold the last result.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = '0;
        end else begin
            chk("mux_err", {7'd0, mux_err}, 8'd0);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_valid: got out_valid 1 expected 0 at %0t", $time);
                end else begin
                    held = sb.pop_front();
                    cmp_all("result", held);
                end
            end else begin
                cmp_all("hold", held);
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = 4'd0; b = 4'd0; and_a = 8'd0;
        d0 = 4'd0; d1 = 4'd0; d2 = 4'd0; d3 = 4'd0; s = 2'd0;
        #1;
        chk("reset.out_valid", {7'd0, out_valid}, 8'd0);
        chk("reset.mux_err", {7'd0, mux_err}, 8'd0);
        cmp_all("reset", '0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        drive(1'b1, 4'b1100, 4'b1010, 8'h00, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0);
        drive(1'b1, 4'd0, 4'd0, 8'hFF, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0);
        drive(1'b1, 4'd0, 4'd0, 8'hFE, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0);
        drive(1'b1, 4'd0, 4'd0, 8'h7F, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0);
        drive(1'b1, 4'd0, 4'd0, 8'h00, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0);
        for (int i = 0; i < 256; i++)
            drive(1'b1, 4'(i), 4'(i >> 2), 8'(i), 4'd0, 4'd0, 4'd0, 4'd0, 2'd0);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 4'd3, 4'd5, 8'hFF, 4'b0000, 4'b0101, 4'b1010, 4'b0001, 2'(i));

        // Hold: changed inputs with in_valid low must not disturb the results.
        drive(1'b1, 4'b1001, 4'b0110, 8'hFF, 4'd1, 4'd2, 4'd3, 4'd4, 2'd2);
        drive(1'b0, 4'b0110, 4'b1111, 8'h00, 4'd9, 4'd9, 4'd9, 4'd9, 2'd1);
        drive(1'b0, 4'b0011, 4'b0000, 8'h0F, 4'd7, 4'd7, 4'd7, 4'd7, 2'd3);

        // Mid-stream reset between edges discards everything in flight.
        drive(1'b1, 4'b1111, 4'b0000, 8'hFF, 4'd8, 4'd9, 4'd10, 4'd11, 2'd3);
        drive(1'b1, 4'b1010, 4'b0101, 8'hFF, 4'd8, 4'd9, 4'd10, 4'd11, 2'd1);
        #1;
        rst_n = 1'b0; in_valid = 1'b0;
        sb.delete();
        #1;
        chk("midreset.out_valid", {7'd0, out_valid}, 8'd0);
        chk("midreset.mux_err", {7'd0, mux_err}, 8'd0);
        cmp_all("midreset", '0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 8'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0);
        drive(1'b1, 4'b0110, 4'b0011, 8'hFF, 4'd1, 4'd2, 4'd3, 4'd4, 2'd1);

        for (int i = 0; i < 256; i++)
            drive(1'b1, 4'(i >> 4), 4'(i), 8'($urandom), 4'($urandom), 4'($urandom),
                  4'($urandom), 4'($urandom), 2'($urandom));
        for (int i = 0; i < 300; i++)
            drive(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 8'($urandom),
                  4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 2'($urandom));

        drive(1'b0, 4'd0, 4'd0, 8'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        chk("drain.pending", 8'(sb.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
